// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: control FSM for a multi-cycle ARM-subset datapath.
// Sequences fetch, decode, ALU, load/store and branch steps, keeps the NZCV
// flag register and faults on illegal encodings or a memory that never answers.
// Build macro MCC_BRANCH_LINK_EN: when defined, BRANCH with Instruction[24]=1
// also writes the return address (PC+4) to R14.
module multi_cycle_controller #(
    parameter int ALUCTRL_W = 3,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [31:0]          Instruction,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           FLAGS,
    output logic [3:0]           State,
    output logic                 Fault
);

    // Memory handshake: while the FSM sits in an access state (FETCH, MEMRD,
    // MEMWR) it holds MemRead or MemWrite and AdrSrc steady; the access
    // completes on the rising CLK edge where MemReady is sampled high, and the
    // request is never withdrawn before then except by reset or timeout.

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    // Counter holds completed wait cycles; it never needs to exceed WAIT_MAX-1.
    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [3:0]       flags_q;
    logic             cond_ex_q;
    logic             cond_ok;
    logic [1:0]       alu_code;
    logic             alu_legal, alu_arith, is_cmp;
    logic             mem_wait, timeout;
    logic             flag_n, flag_z, flag_c, flag_v;
    logic             unused_bits;

    assign unused_bits = ^Instruction[19:0];
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Condition field evaluated against the registered flags.
    always_comb begin
        cond_ok = 1'b1;
        case (Instruction[31:28])
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            default: cond_ok = 1'b1;
        endcase
    end

    // Data-processing opcode decode; CMP shares SUB's ALU operation.
    always_comb begin
        alu_code  = 2'd0;
        alu_legal = 1'b1;
        alu_arith = 1'b0;
        is_cmp    = 1'b0;
        case (Instruction[24:21])
            4'b0100: begin alu_code = 2'd0; alu_arith = 1'b1; end
            4'b0010: begin alu_code = 2'd1; alu_arith = 1'b1; end
            4'b0000: alu_code = 2'd2;
            4'b1100: alu_code = 2'd3;
            4'b1010: begin alu_code = 2'd1; alu_arith = 1'b1; is_cmp = 1'b1; end
            default: alu_legal = 1'b0;
        endcase
    end

    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                      && !MemReady;
    assign timeout  = mem_wait && (wait_q == WAIT_LAST);

    // Next state and datapath controls, decoded from the current state.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = '0;
        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // Gate with RST_N so an async reset cannot leak a PC/IR write.
                if (MemReady && RST_N) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                if (MemReady)     state_d = S_DECODE;
                else if (timeout) state_d = S_FAULT;
            end
            S_DECODE: begin
                if (!cond_ok) begin
                    state_d = S_FETCH;
                end else begin
                    case (Instruction[27:26])
                        2'b00:   state_d = !alu_legal ? S_FAULT :
                                           (Instruction[25] ? S_EXECI : S_EXECR);
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FAULT;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                ALUControl = ALUCTRL_W'(alu_code);
                state_d    = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Instruction[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
                if (MemReady)     state_d = S_MEMWB;
                else if (timeout) state_d = S_FAULT;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b01;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (MemReady)     state_d = S_FETCH;
                else if (timeout) state_d = S_FAULT;
            end
            S_BRANCH: begin
                PCWrite   = 1'b1;
                ResultSrc = 2'b10;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
`ifdef MCC_BRANCH_LINK_EN
                if (Instruction[24]) begin
                    RegWrite  = 1'b1;
                    RegSrc    = 2'b10;
                    ResultSrc = 2'b11;
                end
`endif
                state_d = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Wait count restarts whenever the access ends or the state moves on.
    always_comb begin
        wait_d = '0;
        if (mem_wait && (state_d == state_q)) wait_d = wait_q + 1'b1;
    end

    // State register and memory wait counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Condition result is captured once per instruction, in DECODE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                   cond_ex_q <= 1'b0;
        else if (state_q == S_DECODE) cond_ex_q <= cond_ok;
    end

    // Flag register: N,Z from every S-suffixed ALU op; C,V only from arithmetic.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q <= 4'b0000;
        end else if (((state_q == S_EXECR) || (state_q == S_EXECI))
                     && cond_ex_q && Instruction[20]) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (alu_arith) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign FLAGS = flags_q;
    assign State = state_q;
    assign Fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: instruction-level reference model drives a
// per-cycle expected-output queue; one compare process checks every cycle.
module tb_multi_cycle_controller;
  localparam int ALUCTRL_W = 3;
  localparam int WAIT_MAX  = 15;

  logic                 CLK, RST_N;
  logic [31:0]          Instruction;
  logic [3:0]           ALUFlags;
  logic                 MemReady;
  logic                 PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc;
  logic [1:0]           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           FLAGS, State;
  logic                 Fault;

  multi_cycle_controller #(.ALUCTRL_W(ALUCTRL_W), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .RST_N(RST_N), .Instruction(Instruction), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .FLAGS(FLAGS), .State(State), .Fault(Fault)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]           state;
    logic                 fault;
    logic                 pcw, irw, mrd, mwr, rw, adr;
    logic [1:0]           asa, asb, rs, imm, rsrc;
    logic [ALUCTRL_W-1:0] aluc;
    logic [3:0]           flags;
  } obs_t;
  localparam int W = $bits(obs_t);

  logic [W-1:0] exp_q[$];
  logic [3:0]   state_log[$];
  int           rw_count;
  int           vectors, miscompares;
  logic [3:0]   m_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic obs_t actual_obs();
    obs_t a;
    a.state = State;   a.fault = Fault;
    a.pcw = PCWrite;   a.irw = IRWrite;   a.mrd = MemRead;
    a.mwr = MemWrite;  a.rw = RegWrite;   a.adr = AdrSrc;
    a.asa = ALUSrcA;   a.asb = ALUSrcB;   a.rs = ResultSrc;
    a.imm = ImmSrc;    a.rsrc = RegSrc;   a.aluc = ALUControl;
    a.flags = FLAGS;
    return a;
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge CLK) begin
    obs_t e;
    state_log.push_back(State);
    if (RegWrite) rw_count++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle", 32'(actual_obs()), 32'(e));
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic obs_t base(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.state = st;
    e.flags = m_flags;
    e.fault = (st == 4'd10);
    return e;
  endfunction

  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Driver lives 1 time unit after a rising edge; one call = one cycle.
  task automatic cyc(input logic ready, input logic [3:0] af, input obs_t e);
    MemReady = ready;
    ALUFlags = af;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic access(input obs_t wait_e, input obs_t done_e, input int waits,
                        output bit faulted);
    faulted = 1'b0;
    for (int i = 0; i < waits; i++) begin
      cyc(1'b0, rnd4(), wait_e);
      if (i + 1 == WAIT_MAX) begin
        faulted = 1'b1;
        return;
      end
    end
    cyc(1'b1, rnd4(), done_e);
  endtask

  function automatic obs_t fetch_obs(input bit done);
    obs_t e;
    e = base(4'd0);
    e.mrd = 1'b1; e.asa = 2'b10; e.asb = 2'b10; e.rs = 2'b10;
    if (done) begin e.irw = 1'b1; e.pcw = 1'b1; end
    return e;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input logic [3:0] exec_f,
                           input int fwait, input int mwait, output bit faulted);
    obs_t w;
    bit   f;
    int   code;
    logic [3:0] op;
    faulted = 1'b0;
    Instruction = ins;
    access(fetch_obs(1'b0), fetch_obs(1'b1), fwait, f);
    if (f) begin faulted = 1'b1; return; end
    cyc(1'($urandom_range(0, 1)), rnd4(), base(4'd1));
    if (!cond_true(ins[31:28], m_flags)) return;
    op = ins[24:21];
    case (ins[27:26])
      2'b00: begin
        case (op)
          4'b0100: code = 0;
          4'b0010: code = 1;
          4'b0000: code = 2;
          4'b1100: code = 3;
          4'b1010: code = 1;
          default: code = -1;
        endcase
        if (code < 0) begin faulted = 1'b1; return; end
        w = base(ins[25] ? 4'd7 : 4'd6);
        w.aluc = ALUCTRL_W'(code);
        cyc(1'($urandom_range(0, 1)), exec_f, w);
        if (ins[20]) begin
          m_flags[3:2] = exec_f[3:2];
          if (op == 4'b0100 || op == 4'b0010 || op == 4'b1010) m_flags[1:0] = exec_f[1:0];
        end
        if (op != 4'b1010) begin
          w = base(4'd8); w.rw = 1'b1;
          cyc(1'($urandom_range(0, 1)), rnd4(), w);
        end
      end
      2'b01: begin
        w = base(4'd2); w.asb = 2'b01;
        cyc(1'($urandom_range(0, 1)), rnd4(), w);
        if (ins[20]) begin
          w = base(4'd3); w.mrd = 1'b1; w.adr = 1'b1;
          access(w, w, mwait, f);
          if (f) begin faulted = 1'b1; return; end
          w = base(4'd4); w.rw = 1'b1; w.rs = 2'b01;
          cyc(1'($urandom_range(0, 1)), rnd4(), w);
        end else begin
          w = base(4'd5); w.mwr = 1'b1; w.adr = 1'b1;
          access(w, w, mwait, f);
          if (f) begin faulted = 1'b1; return; end
        end
      end
      2'b10: begin
        w = base(4'd9);
        w.pcw = 1'b1; w.rs = 2'b10; w.asa = 2'b01; w.asb = 2'b01; w.imm = 2'b10;
`ifdef MCC_BRANCH_LINK_EN
        if (ins[24]) begin w.rw = 1'b1; w.rsrc = 2'b10; w.rs = 2'b11; end
`endif
        cyc(1'($urandom_range(0, 1)), rnd4(), w);
      end
      default: faulted = 1'b1;
    endcase
  endtask

  task automatic fault_hold(input int n, input logic ready_fixed, input bit use_fixed);
    for (int i = 0; i < n; i++)
      cyc(use_fixed ? ready_fixed : 1'($urandom_range(0, 1)), rnd4(), base(4'd10));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    MemReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    m_flags = 4'b0000;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit f;
    int seq_add[4];
    int seq_ldr[8];
    vectors = 0; miscompares = 0; rw_count = 0;
    m_flags = 4'b0000;
    RST_N = 1'b0; MemReady = 1'b0; ALUFlags = 4'b0; Instruction = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_state", 32'(State), 32'd0);
    check("rst_flags", 32'(FLAGS), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    RST_N = 1'b1;

    // ADD S=1, always: 0,1,6,8 then FETCH; NZCV all taken
    seq_add = '{0, 1, 6, 8};
    state_log.delete(); rw_count = 0;
    run_instr(32'hE0900000, 4'b1011, 0, 0, f);
    check("add_len", 32'(state_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("add_seq", 32'(state_log[i]), 32'(seq_add[i]));
    check("add_end_state", 32'(State), 32'd0);
    check("add_flags", 32'(FLAGS), 32'b1011);
    check("add_regwrite_cnt", 32'(rw_count), 32'd1);

    // ANDS with Z=1: only N,Z update, C,V kept
    run_instr(32'hE0100000, 4'b0100, 0, 0, f);
    check("and_flags", 32'(FLAGS), 32'b0111);

    // BNE with Z=1: not executed
    state_log.delete(); rw_count = 0;
    run_instr(32'h1A000000, rnd4(), 0, 0, f);
    check("bne_len", 32'(state_log.size()), 32'd2);
    check("bne_state", 32'(State), 32'd0);
    check("bne_regwrite_cnt", 32'(rw_count), 32'd0);

    // LDR with 3 wait cycles in MEMRD
    seq_ldr = '{0, 1, 2, 3, 3, 3, 3, 4};
    state_log.delete(); rw_count = 0;
    run_instr(32'hE5900000, rnd4(), 0, 3, f);
    check("ldr_len", 32'(state_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("ldr_seq", 32'(state_log[i]), 32'(seq_ldr[i]));
    check("ldr_regwrite_cnt", 32'(rw_count), 32'd1);
    check("ldr_fault", 32'(Fault), 32'd0);

    // BL
    state_log.delete(); rw_count = 0;
    run_instr(32'hEB000000, rnd4(), 0, 0, f);
    check("bl_last_state", 32'(state_log[2]), 32'd9);
`ifdef MCC_BRANCH_LINK_EN
    check("bl_regwrite_cnt", 32'(rw_count), 32'd1);
`else
    check("bl_regwrite_cnt", 32'(rw_count), 32'd0);
`endif

    // WAIT_MAX-1 wait cycles in FETCH still complete
    run_instr(32'hE0800000, rnd4(), WAIT_MAX - 1, 0, f);
    check("wait_edge_fault", 32'(Fault), 32'd0);
    check("wait_edge_state", 32'(State), 32'd0);

    // WAIT_MAX wait cycles -> FAULT, sticky under MemReady=1
    run_instr(32'hE0800000, rnd4(), WAIT_MAX, 0, f);
    check("timeout_state", 32'(State), 32'd10);
    check("timeout_fault", 32'(Fault), 32'd1);
    fault_hold(20, 1'b1, 1'b1);
    check("fault_sticky_state", 32'(State), 32'd10);
    check("fault_sticky_flag", 32'(Fault), 32'd1);
    do_reset();

    // Reset dropped in the middle of a store
    run_instr(32'hE0900000, 4'b1111, 0, 0, f);
    Instruction = 32'hE5800000;
    cyc(1'b1, rnd4(), fetch_obs(1'b1));
    cyc(1'b0, rnd4(), base(4'd1));
    begin
      obs_t w;
      w = base(4'd2); w.asb = 2'b01;
      cyc(1'b0, rnd4(), w);
    end
    MemReady = 1'b0;
    #2;
    check("str_memwrite_before", 32'(MemWrite), 32'd1);
    RST_N = 1'b0;
    #1;
    check("str_memwrite_reset", 32'(MemWrite), 32'd0);
    check("str_state_reset", 32'(State), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    m_flags = 4'b0000;
    check("post_rst_state", 32'(State), 32'd0);
    check("post_rst_flags", 32'(FLAGS), 32'd0);
    state_log.delete();
    run_instr(32'hE0900000, rnd4(), 0, 0, f);
    check("restart_fetch", 32'(state_log[0]), 32'd0);
    check("restart_decode", 32'(state_log[1]), 32'd1);

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      logic [31:0] ins, rest;
      logic [3:0]  cond, cmd;
      logic [1:0]  op;
      int r, fw, mw;
      logic [3:0] legal[5];
      legal = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
      state_log.delete();
      cond = 4'($urandom_range(0, 14));
      r = $urandom_range(0, 19);
      op = (r < 11) ? 2'b00 : (r < 15) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      cmd = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : rnd4();
      rest = $urandom;
      ins = {cond, op, 1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1)), rest[19:0]};
      r = $urandom_range(0, 39);
      fw = (r == 0) ? WAIT_MAX : (r == 1) ? WAIT_MAX - 1 : $urandom_range(0, 3);
      r = $urandom_range(0, 39);
      mw = (r == 0) ? WAIT_MAX : (r == 1) ? WAIT_MAX - 1 : $urandom_range(0, 3);
      run_instr(ins, rnd4(), fw, mw, f);
      if (f) begin
        fault_hold($urandom_range(1, 4), 1'b0, 1'b0);
        do_reset();
      end
    end

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
